// File: rtl/calc_entry_fsm.sv
// calc_entry_fsm: three-digit decimal calculator engine.
// Takes scanner keycodes, builds two 0..999 operands, applies add/subtract
// (and multiply when CALC_MUL_EN is defined), and converts the result to BCD
// with a ten-step sequential double-dabble before showing it.
// Optional feature macro: CALC_MUL_EN (enables KEY_MUL as an operator).
module calc_entry_fsm #(
    parameter logic [3:0] KEY_ADD = 4'hA,
    parameter logic [3:0] KEY_SUB = 4'hB,
    parameter logic [3:0] KEY_CLR = 4'hC,
    parameter logic [3:0] KEY_EQ  = 4'hD,
    parameter logic [3:0] KEY_MUL = 4'hE
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] keycode,
    input  logic       keystrobe,
    output logic [3:0] bcd1,
    output logic [3:0] bcd10,
    output logic [3:0] bcd100,
    output logic       neg,
    output logic       err,
    output logic       busy
);

    typedef enum logic [2:0] {
        ENTER_A,
        ENTER_B,
        CONVERT,
        SHOW,
        ERROR
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD,
        OP_SUB,
        OP_MUL
    } op_t;

    state_t      state, state_next;
    op_t         op, op_next;
    logic [9:0]  op_a, op_a_next;
    logic [9:0]  op_b, op_b_next;
    logic [1:0]  count, count_next;
    logic [3:0]  bcd1_next, bcd10_next, bcd100_next;
    logic        neg_next;
    logic [9:0]  res_mag, res_mag_next;
    logic        res_neg, res_neg_next;
    logic [9:0]  conv_bin, conv_bin_next;
    logic [11:0] conv_bcd, conv_bcd_next;
    logic [3:0]  conv_cnt, conv_cnt_next;

    logic        key_digit, key_op, key_clr, key_eq;
    op_t         key_op_code;

    logic        a_ge_b;
    logic [10:0] sum;
    logic [9:0]  diff;
    logic [19:0] res_wide;
    logic        res_is_neg;
    logic        res_over;

    logic [11:0] dd_adj;
    logic [11:0] dd_bcd_next;
    logic [9:0]  dd_bin_next;

    // Shift a decimal digit into the low end of a binary operand.
    function automatic logic [9:0] append_digit(input logic [9:0] value,
                                                input logic [3:0] digit);
        return value * 10'd10 + {6'd0, digit};
    endfunction

    // Classify the strobed keycode; 4'hF and unused codes fall through as no key.
    always_comb begin
        key_digit   = keystrobe && (keycode <= 4'd9);
        key_clr     = keystrobe && (keycode == KEY_CLR);
        key_eq      = keystrobe && (keycode == KEY_EQ);
        key_op      = 1'b0;
        key_op_code = OP_ADD;
        if (keystrobe) begin
            if (keycode == KEY_ADD) begin
                key_op      = 1'b1;
                key_op_code = OP_ADD;
            end else if (keycode == KEY_SUB) begin
                key_op      = 1'b1;
                key_op_code = OP_SUB;
            end
`ifdef CALC_MUL_EN
            else if (keycode == KEY_MUL) begin
                key_op      = 1'b1;
                key_op_code = OP_MUL;
            end
`endif
        end
    end

    // Compute the magnitude and sign of the pending operation from the operands.
    always_comb begin
        a_ge_b     = (op_a >= op_b);
        sum        = {1'b0, op_a} + {1'b0, op_b};
        diff       = a_ge_b ? (op_a - op_b) : (op_b - op_a);
        res_wide   = {9'd0, sum};
        res_is_neg = 1'b0;
        case (op)
            OP_SUB: begin
                res_wide   = {10'd0, diff};
                res_is_neg = !a_ge_b;
            end
`ifdef CALC_MUL_EN
            OP_MUL: res_wide = {10'd0, op_a} * {10'd0, op_b};
`endif
            default: res_wide = {9'd0, sum};
        endcase
        res_over = (res_wide > 20'd999);
    end

    // One double-dabble step: add 3 to any digit of 5 or more, then shift in the next bit.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            dd_adj[4*i +: 4] = (conv_bcd[4*i +: 4] >= 4'd5) ? conv_bcd[4*i +: 4] + 4'd3
                                                             : conv_bcd[4*i +: 4];
        end
        dd_bcd_next = (dd_adj << 1) | {11'd0, conv_bin[9]};
        dd_bin_next = conv_bin << 1;
    end

    // Next-state and datapath updates for every key in every state; clear wins everywhere.
    always_comb begin
        state_next    = state;
        op_next       = op;
        op_a_next     = op_a;
        op_b_next     = op_b;
        count_next    = count;
        bcd1_next     = bcd1;
        bcd10_next    = bcd10;
        bcd100_next   = bcd100;
        neg_next      = neg;
        res_mag_next  = res_mag;
        res_neg_next  = res_neg;
        conv_bin_next = conv_bin;
        conv_bcd_next = conv_bcd;
        conv_cnt_next = conv_cnt;

        if (key_clr) begin
            state_next    = ENTER_A;
            op_next       = OP_ADD;
            op_a_next     = 10'd0;
            op_b_next     = 10'd0;
            count_next    = 2'd0;
            bcd1_next     = 4'd0;
            bcd10_next    = 4'd0;
            bcd100_next   = 4'd0;
            neg_next      = 1'b0;
            res_mag_next  = 10'd0;
            res_neg_next  = 1'b0;
            conv_bin_next = 10'd0;
            conv_bcd_next = 12'd0;
            conv_cnt_next = 4'd0;
        end else begin
            case (state)
                ENTER_A: begin
                    if (key_digit && (count != 2'd3)) begin
                        op_a_next   = append_digit(op_a, keycode);
                        count_next  = count + 2'd1;
                        bcd100_next = bcd10;
                        bcd10_next  = bcd1;
                        bcd1_next   = keycode;
                    end else if (key_op) begin
                        op_next    = key_op_code;
                        op_b_next  = 10'd0;
                        count_next = 2'd0;
                        state_next = ENTER_B;
                    end
                end
                ENTER_B: begin
                    if (key_digit && (count != 2'd3)) begin
                        op_b_next  = append_digit(op_b, keycode);
                        count_next = count + 2'd1;
                        if (count == 2'd0) begin
                            bcd100_next = 4'd0;
                            bcd10_next  = 4'd0;
                        end else begin
                            bcd100_next = bcd10;
                            bcd10_next  = bcd1;
                        end
                        bcd1_next = keycode;
                    end else if (key_op && (count == 2'd0)) begin
                        op_next = key_op_code;
                    end else if (key_eq) begin
                        if (res_over) begin
                            state_next  = ERROR;
                            bcd1_next   = 4'hE;
                            bcd10_next  = 4'hE;
                            bcd100_next = 4'hE;
                        end else begin
                            state_next    = CONVERT;
                            res_mag_next  = res_wide[9:0];
                            res_neg_next  = res_is_neg;
                            conv_bin_next = res_wide[9:0];
                            conv_bcd_next = 12'd0;
                            conv_cnt_next = 4'd0;
                        end
                    end
                end
                CONVERT: begin
                    conv_bin_next = dd_bin_next;
                    conv_bcd_next = dd_bcd_next;
                    conv_cnt_next = conv_cnt + 4'd1;
                    if (conv_cnt == 4'd9) begin
                        bcd100_next = dd_bcd_next[11:8];
                        bcd10_next  = dd_bcd_next[7:4];
                        bcd1_next   = dd_bcd_next[3:0];
                        neg_next    = res_neg;
                        state_next  = SHOW;
                    end
                end
                SHOW: begin
                    if (key_digit) begin
                        op_a_next   = {6'd0, keycode};
                        count_next  = 2'd1;
                        neg_next    = 1'b0;
                        bcd100_next = 4'd0;
                        bcd10_next  = 4'd0;
                        bcd1_next   = keycode;
                        state_next  = ENTER_A;
                    end else if (key_op && !neg) begin
                        op_a_next  = res_mag;
                        op_b_next  = 10'd0;
                        count_next = 2'd0;
                        op_next    = key_op_code;
                        state_next = ENTER_B;
                    end
                end
                ERROR: begin
                    state_next = ERROR;
                end
                default: begin
                    state_next = ENTER_A;
                end
            endcase
        end
    end

    // Register the state and all datapath values; reset returns to an empty entry.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ENTER_A;
            op       <= OP_ADD;
            op_a     <= 10'd0;
            op_b     <= 10'd0;
            count    <= 2'd0;
            bcd1     <= 4'd0;
            bcd10    <= 4'd0;
            bcd100   <= 4'd0;
            neg      <= 1'b0;
            res_mag  <= 10'd0;
            res_neg  <= 1'b0;
            conv_bin <= 10'd0;
            conv_bcd <= 12'd0;
            conv_cnt <= 4'd0;
        end else begin
            state    <= state_next;
            op       <= op_next;
            op_a     <= op_a_next;
            op_b     <= op_b_next;
            count    <= count_next;
            bcd1     <= bcd1_next;
            bcd10    <= bcd10_next;
            bcd100   <= bcd100_next;
            neg      <= neg_next;
            res_mag  <= res_mag_next;
            res_neg  <= res_neg_next;
            conv_bin <= conv_bin_next;
            conv_bcd <= conv_bcd_next;
            conv_cnt <= conv_cnt_next;
        end
    end

    assign busy = (state == CONVERT);
    assign err  = (state == ERROR);

endmodule
